// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and MUL sequencer state encoding
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    // 2'd3 is unused and falls back to IDLE in the sequencer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/full_adder_8bits.sv
// rtl/full_adder_8bits.sv - 8-bit ripple-carry adder used by the MUL datapath
module full_adder_8bits
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Suma,
    output logic             Cout
);

    // Ripple the carry from bit 0 upwards; the carry out of bit 7 becomes Cout
    always_comb begin
        logic c;
        c    = Cin;
        Suma = '0;
        for (int i = 0; i < WIDTH; i++) begin
            Suma[i] = A[i] ^ B[i] ^ c;
            c       = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        Cout = c;
    end

endmodule

// File: rtl/mult_shift_add_8bits.sv
// rtl/mult_shift_add_8bits.sv - sequential 8x8 unsigned shift-and-add multiplier
module mult_shift_add_8bits
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Producto,
    output logic               Alto
);

    mul_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     phi_q, phi_d;
    logic [WIDTH-1:0]     plo_q, plo_d;
    logic [2*WIDTH-1:0]   producto_q, producto_d;
    logic                 alto_q, alto_d;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     suma;
    logic                 cout;
    logic [WIDTH-1:0]     step_phi;
    logic [WIDTH-1:0]     step_plo;

    // Partial product is added only when the current multiplier LSB is set
    assign add_b = plo_q[0] ? mcand_q : '0;

    full_adder_8bits u_adder (
        .A    (phi_q),
        .B    (add_b),
        .Cin  (1'b0),
        .Suma (suma),
        .Cout (cout)
    );

    // Shift the 17-bit {Cout, Suma, Plo} right by one; Cout lands in the Phi MSB
    assign step_phi = {cout, suma[WIDTH-1:1]};
    assign step_plo = {suma[0], plo_q[WIDTH-1:1]};

    // Next-state, datapath load/step and result capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        phi_d      = phi_q;
        plo_d      = plo_q;
        producto_d = producto_q;
        alto_d     = alto_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = A;
                    phi_d   = '0;
                    plo_d   = B;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                phi_d = step_phi;
                plo_d = step_plo;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    producto_d = {step_phi, step_plo};
                    alto_d     = |step_phi;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    mcand_d = A;
                    phi_d   = '0;
                    plo_d   = B;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            phi_q      <= '0;
            plo_q      <= '0;
            producto_q <= '0;
            alto_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            phi_q      <= phi_d;
            plo_q      <= plo_d;
            producto_q <= producto_d;
            alto_q     <= alto_d;
        end
    end

    assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign Producto = producto_q;
    assign Alto     = alto_q;

endmodule
